keypad_scanner: RTL and testbench
=================================

# keypad_scanner

- Scans a 4x4 matrix keypad by strobing its columns and reading its rows: the input-side counterpart of the multiplexed FND display driver.
- Drives one column low at a time, samples the rows at the end of each column dwell, and assembles a 16-key snapshot per frame.
- Debounces the snapshot across frames and emits a single-cycle `key_valid` pulse with a 4-bit key code.
- Sits beside the FND controller in the top level; its key code feeds the same datapath that supplies display data.

## Interface
- `FCOUNT`, default 500_000: clk cycles per column dwell (100 MHz gives 200 Hz column rate, 50 Hz frame rate).
- `DEBOUNCE`, default 3: number of consecutive identical frame results required to accept a press or release; legal range 1..15.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `row`  in  4  keypad rows; active-low with external pull-ups; asynchronous to `clk`.
- `col`  out  4  column strobes; active-low one-hot.
- `key`  out  4  code of the last accepted key, `row_idx*4 + col_idx`.
- `key_valid`  out  1  one-cycle pulse when a new key is accepted.
- `key_held`  out  1  high while the accepted key remains debounced-pressed.

## Operation
- **Tick:** a 1-cycle `tick` is asserted every `FCOUNT` clks.
- **Column counter:** 2-bit `col_idx` advances on `tick` and wraps 3→0.
  - `col` mapping: 00→1110, 01→1101, 10→1011, 11→0111.
- **Row input:** `row` passes through a 2-flop synchronizer and is inverted to active-high `row_s`.
- **Sampling:** on the `tick` cycle, `row_s` is written into `snap[col_idx*4 +: 4]`, then the column advances on the same edge.
- **Frame end:** the `tick` with `col_idx==3` ends a frame. The full snapshot (including the bits just sampled) is classified into a candidate:
  - no bits set → NONE;
  - exactly one bit set → KEY(code);
  - two or more bits set → MULTI.
- **Debounce:** a 4-bit stable counter.
  - Candidate equal to the previous frame's candidate → counter increments, saturating at `DEBOUNCE`.
  - Otherwise → counter = 1 and the previous candidate register is updated.
- **FSM states:**
  - RELEASED (reset state, `key_held`=0).
  - HELD (`key_held`=1).
- **Transitions** (evaluated at frame end, on the frame where the counter reaches `DEBOUNCE`):
  - RELEASED + KEY(c) → HELD: `key`←c, `key_valid` pulse.
  - HELD + KEY(c), c≠`key` → HELD: `key`←c, `key_valid` pulse (roll-over).
  - HELD + KEY(c), c==`key` → no action; no repeat pulse.
  - HELD + NONE → RELEASED: `key` retains its last value.
  - MULTI in any state → no transition and no pulse; the current state is held (ghost rejection).
- **Reset:** reset at any time aborts the frame and clears `snap`, the counter, the previous candidate and the FSM; scanning restarts at column 0.

## Timing
- Reset values:
  - `col`=1110, `key`=0, `key_valid`=0, `key_held`=0;
  - tick counter=0, `col_idx`=0, previous candidate=NONE, stable counter=0.
- `col` is registered and changes on the clk edge where `tick`=1.
- `key`, `key_valid` and `key_held` are registered and update on the frame-end edge.
  - `key_valid` is high for exactly that one cycle.
- Dwell per column is `FCOUNT` clks, so a frame is 4·`FCOUNT` clks.
- Synchronizer latency is 2 clks. A row change less than 2 clks before a `tick` may be sampled in either its old or new state; the debounce logic absorbs this.
- Press-to-`key_valid` latency: between (`DEBOUNCE`−1) and `DEBOUNCE` full frames after the first frame that fully sees the press.
- `key_valid` never asserts on two consecutive frames for the same code.

## Structure
- Shared package/header `keypad_defs`:
  - column strobe constants (`COL0`..`COL3`);
  - candidate type encoding: NONE=2'd0, KEY=2'd1, MULTI=2'd2;
  - FSM state encoding: RELEASED=1'b0, HELD=1'b1.
- Sub-module `scan_tick_gen` (parameter `FCOUNT`; ports `clk`, `reset`, `tick`): a free-running counter that pulses `tick` on count `FCOUNT`−1 and then wraps to 0.
- Top level contains the synchronizer, column counter/decoder, snapshot register, classifier (popcount plus priority index) and the debounce FSM.

## Test plan
Parameters for all scenarios: `FCOUNT`=4, `DEBOUNCE`=3. Keypad model: `row[r]`=0 while `col[c]`=0 and key (r,c) is pressed; otherwise `row` is pulled high.

1. **Reset:** drop `reset` mid-frame for 3 clks → `col`=1110, `key`=0, `key_valid`=0 and `key_held`=0 immediately; the first post-reset `tick` moves `col` to 1101.
2. **Single press:** press key (2,1), code 9, steadily → exactly one `key_valid` pulse with `key`=9, on the 3rd frame end after the first frame that fully sees the press; `key_held`=1 and there are no further pulses while it is held.
3. **Bounce:** toggle key 5 every 5 clks for 2 frames, then hold it → no pulse during bouncing; a single pulse with `key`=5 follows 3 stable frames; on release, `key_held` falls 3 frames after the key is released.
4. **Roll-over:** hold key 0 until accepted, then switch directly to key 15 with no NONE frames → second pulse with `key`=15 after 3 frames; `key_held` stays 1 throughout.
5. **Ghosting:** hold key 3 until accepted, then add key 6 → no pulse, `key`=3 and `key_held`=1 retained; release key 3 while keeping key 6 → pulse with `key`=6 after 3 frames.
6. **Reset during hold:** with key 12 accepted, pulse `reset` low → outputs return to reset values; the still-pressed key 12 is re-accepted (one new pulse) 3 frames after reset releases.

Source files
------------

// File: rtl/keypad_defs.sv
// Shared definitions for the keypad scanner: column strobes, frame
// candidate encoding and debounce FSM states.
package keypad_defs;

    localparam logic [3:0] COL0 = 4'b1110;
    localparam logic [3:0] COL1 = 4'b1101;
    localparam logic [3:0] COL2 = 4'b1011;
    localparam logic [3:0] COL3 = 4'b0111;

    typedef enum logic [1:0] {
        CAND_NONE  = 2'd0,
        CAND_KEY   = 2'd1,
        CAND_MULTI = 2'd2
    } cand_kind_t;

    // A frame result; code is forced to zero unless kind is CAND_KEY so that
    // two NONE or two MULTI frames compare equal.
    typedef struct packed {
        cand_kind_t kind;
        logic [3:0] code;
    } cand_t;

    typedef enum logic {
        RELEASED = 1'b0,
        HELD     = 1'b1
    } state_t;

    function automatic logic [3:0] col_strobe(input logic [1:0] idx);
        logic [3:0] s;
        case (idx)
            2'd0:    s = COL0;
            2'd1:    s = COL1;
            2'd2:    s = COL2;
            default: s = COL3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running dwell counter: pulses tick for one clk every FCOUNT clks.
module scan_tick_gen #(
    parameter int FCOUNT = 500_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int            CW   = (FCOUNT > 1) ? $clog2(FCOUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(FCOUNT - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // Count up to FCOUNT-1, then wrap to zero on the tick cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes columns, snapshots rows once per
// frame, classifies the snapshot and debounces it into key events.
module keypad_scanner
    import keypad_defs::*;
#(
    parameter int FCOUNT   = 500_000,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);
    localparam logic [3:0] DEB_LIM = 4'(DEBOUNCE);

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
        return n;
    endfunction

    // Lowest set bit wins; only meaningful when exactly one bit is set.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
        return idx;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= DEB_LIM) ? DEB_LIM : v + 4'd1;
    endfunction

    logic        tick;
    logic [3:0]  row_p0, row_p1, row_s;
    logic [1:0]  col_idx;
    logic [15:0] snap, snap_full;
    logic [4:0]  ones;
    logic [3:0]  bit_idx;
    logic        frame_end;
    cand_t       cand, prev_cand;
    logic [3:0]  stable_cnt, stable_nxt;
    state_t      state, state_nxt;
    logic [3:0]  key_nxt;
    logic        valid_nxt;

    scan_tick_gen #(.FCOUNT(FCOUNT)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign row_s     = ~row_p1;
    assign frame_end = tick && (col_idx == 2'd3);
    assign key_held  = (state == HELD);

    // Two-flop synchronizer for the asynchronous, pulled-up row lines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_p0 <= 4'hF;
            row_p1 <= 4'hF;
        end else begin
            row_p0 <= row;
            row_p1 <= row_p0;
        end
    end

    // Snapshot with the current column's rows merged in, as seen on a tick.
    always_comb begin
        snap_full = snap;
        snap_full[{col_idx, 2'b00} +: 4] = row_s;
    end

    // Column scan: store this column's rows and step the strobe on each tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap    <= '0;
            col_idx <= 2'd0;
            col     <= COL0;
        end else if (tick) begin
            snap    <= snap_full;
            col_idx <= col_idx + 2'd1;
            col     <= col_strobe(col_idx + 2'd1);
        end
    end

    // Classify the frame; snapshot bit c*4+r maps to key code r*4+c.
    always_comb begin
        ones    = popcount16(snap_full);
        bit_idx = lowest_set(snap_full);
        cand    = '{kind: CAND_NONE, code: 4'd0};
        if (ones == 5'd1) begin
            cand = '{kind: CAND_KEY, code: {bit_idx[1:0], bit_idx[3:2]}};
        end else if (ones != 5'd0) begin
            cand.kind = CAND_MULTI;
        end
    end

    // Stable-frame counter and previous candidate, updated once per frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_cnt <= 4'd0;
            prev_cand  <= '{kind: CAND_NONE, code: 4'd0};
        end else if (frame_end) begin
            stable_cnt <= stable_nxt;
            if (cand != prev_cand) prev_cand <= cand;
        end
    end

    // FSM next state and key outputs; acts only on a debounced frame result.
    always_comb begin
        stable_nxt = (cand == prev_cand) ? sat_inc(stable_cnt) : 4'd1;
        state_nxt  = state;
        key_nxt    = key;
        valid_nxt  = 1'b0;
        if (frame_end && (stable_nxt == DEB_LIM)) begin
            case (cand.kind)
                CAND_KEY: begin
                    if ((state == RELEASED) || (cand.code != key)) begin
                        state_nxt = HELD;
                        key_nxt   = cand.code;
                        valid_nxt = 1'b1;
                    end
                end
                CAND_NONE: state_nxt = RELEASED;
                default:   state_nxt = state;
            endcase
        end
    end

    // FSM state and registered key outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RELEASED;
            key       <= 4'd0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            key       <= key_nxt;
            key_valid <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a keypad matrix model and a
// frame-level reference model compared every cycle.
module tb_keypad_scanner;
    localparam int FC    = 4;
    localparam int DEB   = 3;
    localparam int FRAME = 4 * FC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row, col, key;
    logic        key_valid, key_held;
    logic [15:0] pressed = 16'h0000;   // bit n set = key with code n pressed

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    keypad_scanner #(.FCOUNT(FC), .DEBOUNCE(DEB)) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is strobed.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    int         m_k;            // clock edges since reset released
    logic [3:0] rq[$];          // row values seen at recent edges, newest first
    logic [3:0] m_seen[4];      // active-high rows seen per column this frame
    int         m_prev;         // -1 none, 0..15 key, 16 multi
    int         m_run;
    logic [3:0] m_key;
    logic       m_held, m_valid;

    task automatic model_clear();
        m_k = 0; rq.delete(); m_prev = -1; m_run = 0;
        m_key = 4'd0; m_held = 1'b0; m_valid = 1'b0;
        for (int c = 0; c < 4; c++) m_seen[c] = 4'h0;
    endtask

    task automatic model_frame();
        int n, code, cand;
        n = 0; code = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (m_seen[c][r]) begin n++; code = r*4 + c; end
        cand = (n == 0) ? -1 : (n == 1) ? code : 16;
        if (cand == m_prev) m_run++;
        else begin m_run = 1; m_prev = cand; end
        if (m_run >= DEB) begin
            if (cand >= 0 && cand < 16) begin
                if (!m_held || cand != int'(m_key)) begin
                    m_held = 1'b1; m_key = cand[3:0]; m_valid = 1'b1;
                end
            end else if (cand == -1) begin
                m_held = 1'b0;
            end
        end
    endtask

    task automatic model_edge();
        int c;
        m_k++;
        rq.push_front(row);
        if (rq.size() > 3) void'(rq.pop_back());
        m_valid = 1'b0;
        if (m_k % FC == 0) begin
            c = ((m_k - 1) / FC) % 4;
            m_seen[c] = (rq.size() >= 3) ? ~rq[2] : 4'h0;
            if (c == 3) model_frame();
        end
    endtask

    function automatic logic [3:0] exp_col();
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << ((m_k / FC) % 4));
    endfunction

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_clear();
            else        model_edge();
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (key_valid === 1'b1) pulses++;
            chk("col", col, exp_col());
            chk("key", key, m_key);
            chk("key_valid", key_valid, m_valid);
            chk("key_held", key_held, m_held);
        end
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        logic [15:0] keys;
        int          frames;
        logic [3:0]  exp_key;
        logic        exp_held;
        int          exp_pulses;
    } step_t;

    step_t tbl[17];

    task automatic align_frame();
        int guard;
        guard = 0;
        while ((m_k % FRAME) != 0 && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        chk("align", 16'(m_k % FRAME), 16'd0);
    endtask

    task automatic run_frames(input int n);
        repeat (n * FRAME) @(negedge clk);
        #1;
    endtask

    initial begin
        int pc0;
        logic [15:0] m;

        tbl[0]  = '{16'h0000, 4, 4'd0,  1'b0, 0};
        tbl[1]  = '{16'h0200, 4, 4'd9,  1'b1, 1};
        tbl[2]  = '{16'h0200, 4, 4'd9,  1'b1, 0};
        tbl[3]  = '{16'h0000, 4, 4'd9,  1'b0, 0};
        tbl[4]  = '{16'h0001, 4, 4'd0,  1'b1, 1};
        tbl[5]  = '{16'h8000, 4, 4'd15, 1'b1, 1};
        tbl[6]  = '{16'h0008, 4, 4'd3,  1'b1, 1};
        tbl[7]  = '{16'h0048, 4, 4'd3,  1'b1, 0};
        tbl[8]  = '{16'h0040, 4, 4'd6,  1'b1, 1};
        tbl[9]  = '{16'h1000, 4, 4'd12, 1'b1, 1};
        tbl[10] = '{16'h0000, 2, 4'd12, 1'b1, 0};
        tbl[11] = '{16'h0000, 2, 4'd12, 1'b0, 0};
        tbl[12] = '{16'h0020, 2, 4'd12, 1'b0, 0};
        tbl[13] = '{16'h0020, 2, 4'd5,  1'b1, 1};
        tbl[14] = '{16'h0000, 4, 4'd5,  1'b0, 0};
        tbl[15] = '{16'h0006, 4, 4'd5,  1'b0, 0};
        tbl[16] = '{16'h0000, 4, 4'd5,  1'b0, 0};

        // Reset mid-frame
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_col", col, 4'b1110);
        chk("rst_key", key, 4'd0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_held", key_held, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("rst_col_before_tick", col, 4'b1110);
        @(negedge clk);
        #1 chk("rst_col_after_tick", col, 4'b1101);

        // Table of frame-aligned key patterns
        align_frame();
        for (int i = 0; i < 17; i++) begin
            pressed = tbl[i].keys;
            pc0 = pulses;
            run_frames(tbl[i].frames);
            chk($sformatf("step%0d_key", i), key, tbl[i].exp_key);
            chk($sformatf("step%0d_held", i), key_held, tbl[i].exp_held);
            chk($sformatf("step%0d_pulses", i), 16'(pulses - pc0), 16'(tbl[i].exp_pulses));
        end

        // Bounce on key 5, then hold, then release
        align_frame();
        pc0 = pulses;
        for (int t = 0; t < 2 * FRAME; t++) begin
            if (t % 5 == 0) pressed = pressed ^ 16'h0020;
            @(negedge clk);
        end
        #1 chk("bounce_pulses", 16'(pulses - pc0), 16'd0);
        pressed = 16'h0020;
        run_frames(4);
        chk("bounce_total_pulses", 16'(pulses - pc0), 16'd1);
        chk("bounce_key", key, 4'd5);
        chk("bounce_held", key_held, 1'b1);
        pressed = 16'h0000;
        run_frames(2);
        chk("release_held_2f", key_held, 1'b1);
        run_frames(2);
        chk("release_held_4f", key_held, 1'b0);

        // Reset while key 12 is held
        pressed = 16'h1000;
        run_frames(4);
        chk("hold12_key", key, 4'd12);
        chk("hold12_held", key_held, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk("rst2_key", key, 4'd0);
        chk("rst2_held", key_held, 1'b0);
        chk("rst2_col", col, 4'b1110);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        pc0 = pulses;
        run_frames(4);
        chk("reaccept_pulses", 16'(pulses - pc0), 16'd1);
        chk("reaccept_key", key, 4'd12);
        chk("reaccept_held", key_held, 1'b1);

        // Randomized key activity, checked cycle by cycle against the model
        for (int i = 0; i < 60; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            m = 16'h0000;
            if (sel >= 2) m[$urandom_range(0, 15)] = 1'b1;
            if (sel >= 8) m[$urandom_range(0, 15)] = 1'b1;
            pressed = m;
            repeat ($urandom_range(3, 70)) @(negedge clk);
        end
        pressed = 16'h0000;
        run_frames(5);
        chk("final_released", key_held, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
